// File: rtl/matrix_result_reader.sv
// matrix_result_reader: reads the packed 5x5 result word and streams its elements over valid/ready.
// Define MATRIX_READER_COLMAJOR_EN to stream in column-major order.
module matrix_result_reader #(
  parameter int RESULT_ADDR = 2,
  parameter int RAM_LATENCY = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [7:0]   ram_address,
  input  logic [255:0] ram_q,
  output logic [7:0]   elem_data,
  output logic [2:0]   elem_row,
  output logic [2:0]   elem_col,
  output logic         elem_valid,
  input  logic         elem_ready
);
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, STREAM} state_t;
  state_t r_state, w_next;
  logic [2:0] r_cnt;
  logic [199:0] r_buf;
  logic w_hs, w_last, w_unused;
  logic [2:0] w_nrow, w_ncol;
  logic [4:0] w_nk;
  assign w_unused = ^ram_q[255:200];
  assign busy = r_state != IDLE;
  assign elem_valid = r_state == STREAM;
  assign w_hs = elem_valid && elem_ready;
  assign w_last = elem_row == 3'd4 && elem_col == 3'd4;
`ifdef MATRIX_READER_COLMAJOR_EN
  assign w_nrow = elem_row == 3'd4 ? 3'd0 : elem_row + 3'd1;
  assign w_ncol = elem_row == 3'd4 ? elem_col + 3'd1 : elem_col;
`else
  assign w_ncol = elem_col == 3'd4 ? 3'd0 : elem_col + 3'd1;
  assign w_nrow = elem_col == 3'd4 ? elem_row + 3'd1 : elem_row;
`endif
  assign w_nk = 5'(w_nrow) * 5'd5 + 5'(w_ncol);
  always_ff @(posedge clock)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RAM_LATENCY == 1 ? CAPTURE : WAIT;
      WAIT:    if (r_cnt == 3'(RAM_LATENCY - 2)) w_next = CAPTURE;
      CAPTURE: w_next = STREAM;
      STREAM:  if (w_hs && w_last) w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      done        <= 1'b0;
      ram_address <= 8'd0;
      r_cnt       <= 3'd0;
      r_buf       <= '0;
      elem_data   <= 8'd0;
      elem_row    <= 3'd0;
      elem_col    <= 3'd0;
    end else begin
      done <= w_hs && w_last;
      if (r_state == IDLE && start) begin
        ram_address <= 8'(RESULT_ADDR);
        r_cnt       <= 3'd0;
      end
      if (r_state == WAIT) r_cnt <= r_cnt + 3'd1;
      if (r_state == CAPTURE) begin
        r_buf     <= ram_q[199:0];
        elem_data <= ram_q[7:0];
        elem_row  <= 3'd0;
        elem_col  <= 3'd0;
      end
      // the final handshake leaves the index on (4,4); the next capture rewinds it
      if (w_hs && !w_last) begin
        elem_row  <= w_nrow;
        elem_col  <= w_ncol;
        elem_data <= r_buf[{w_nk, 3'b000} +: 8];
      end
    end
  end
endmodule

// File: tb/tb_matrix_result_reader.sv
// tb_matrix_result_reader: directed checks of matrix_result_reader streaming, backpressure and reset.
module tb_matrix_result_reader;
  logic clock = 0, reset = 1, start = 0, elem_ready = 0;
  logic busy, done, elem_valid;
  logic [7:0] ram_address, elem_data;
  logic [2:0] elem_row, elem_col;
  logic [255:0] ram_q, r_word = '0;
  int n_tests = 0, n_fail = 0;
  assign ram_q = ram_address == 8'd2 ? r_word : '0;
  always #5 clock = ~clock;
  matrix_result_reader #(.RESULT_ADDR(2), .RAM_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .ram_address(ram_address), .ram_q(ram_q), .elem_data(elem_data),
    .elem_row(elem_row), .elem_col(elem_col), .elem_valid(elem_valid),
    .elem_ready(elem_ready)
  );
  function automatic int exp_k(int i);
`ifdef MATRIX_READER_COLMAJOR_EN
    return (i % 5) * 5 + i / 5;
`else
    return i;
`endif
  endfunction
  function automatic logic [255:0] inc_word();
    logic [255:0] w = '0;
    for (int k = 0; k < 25; k++) w[8*k +: 8] = 8'(k);
    return w;
  endfunction
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic launch();
    start = 1;
    tick();
    start = 0;
    tick(2);
  endtask
  task automatic test_reset();
    reset = 1;
    tick(2);
    n_tests++;
    if ({ram_address, busy, done, elem_valid, elem_data, elem_row, elem_col} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset: addr=%0d busy=%b done=%b valid=%b data=%h row=%0d col=%0d, required all 0",
               ram_address, busy, done, elem_valid, elem_data, elem_row, elem_col);
    end
    reset = 0;
    tick();
  endtask
  task automatic test_stream();
    r_word = inc_word();
    elem_ready = 1;
    start = 1;
    tick();
    start = 0;
    n_tests++;
    if (busy !== 1 || ram_address !== 8'd2 || elem_valid !== 0) begin
      n_fail++;
      $display("FAIL stream_e0: busy=%b addr=%0d valid=%b, required 1 2 0", busy, ram_address, elem_valid);
    end
    tick();
    n_tests++;
    if (elem_valid !== 0) begin
      n_fail++;
      $display("FAIL stream_e1: valid=%b, required 0", elem_valid);
    end
    tick();
    r_word = '0;
    for (int i = 0; i < 25; i++) begin
      n_tests++;
      if (elem_valid !== 1 || done !== 0 || elem_data !== 8'(exp_k(i)) ||
          elem_row !== 3'(exp_k(i) / 5) || elem_col !== 3'(exp_k(i) % 5)) begin
        n_fail++;
        $display("FAIL stream_elem%0d: valid=%b done=%b data=%0d row=%0d col=%0d, required 1 0 %0d %0d %0d",
                 i, elem_valid, done, elem_data, elem_row, elem_col, exp_k(i), exp_k(i) / 5, exp_k(i) % 5);
      end
      tick();
    end
    n_tests++;
    if (done !== 1 || busy !== 0 || elem_valid !== 0) begin
      n_fail++;
      $display("FAIL stream_done: done=%b busy=%b valid=%b, required 1 0 0", done, busy, elem_valid);
    end
    tick();
    n_tests++;
    if (done !== 0 || busy !== 0 || ram_address !== 8'd2) begin
      n_fail++;
      $display("FAIL stream_after: done=%b busy=%b addr=%0d, required 0 0 2", done, busy, ram_address);
    end
  endtask
  task automatic test_backpressure();
    r_word = inc_word();
    elem_ready = 1;
    launch();
    tick(7);
    elem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (elem_valid !== 1 || elem_data !== 8'(exp_k(7)) || elem_row !== 3'(exp_k(7) / 5) ||
          elem_col !== 3'(exp_k(7) % 5)) begin
        n_fail++;
        $display("FAIL backpressure_hold%0d: valid=%b data=%0d row=%0d col=%0d, required 1 %0d %0d %0d",
                 c, elem_valid, elem_data, elem_row, elem_col, exp_k(7), exp_k(7) / 5, exp_k(7) % 5);
      end
    end
    elem_ready = 1;
    tick();
    n_tests++;
    if (elem_data !== 8'(exp_k(8))) begin
      n_fail++;
      $display("FAIL backpressure_next: data=%0d, required %0d", elem_data, exp_k(8));
    end
    tick(17);
    n_tests++;
    if (done !== 1) begin
      n_fail++;
      $display("FAIL backpressure_done: done=%b, required 1", done);
    end
    tick();
  endtask
  task automatic test_signed();
    r_word = inc_word();
    r_word[255:200] = '1;
    r_word[7:0] = 8'hFB;
    r_word[199:192] = 8'h80;
    elem_ready = 1;
    launch();
    n_tests++;
    if (elem_data !== 8'hFB || elem_row !== 0 || elem_col !== 0) begin
      n_fail++;
      $display("FAIL signed_first: data=%h row=%0d col=%0d, required fb 0 0", elem_data, elem_row, elem_col);
    end
    tick(24);
    n_tests++;
    if (elem_data !== 8'h80 || elem_row !== 3'd4 || elem_col !== 3'd4) begin
      n_fail++;
      $display("FAIL signed_last: data=%h row=%0d col=%0d, required 80 4 4", elem_data, elem_row, elem_col);
    end
    tick();
    n_tests++;
    if (done !== 1) begin
      n_fail++;
      $display("FAIL signed_done: done=%b, required 1", done);
    end
    tick();
  endtask
  task automatic test_ignored_start();
    int n_done = 0;
    r_word = inc_word();
    elem_ready = 1;
    launch();
    tick(12);
    start = 1;
    tick();
    start = 0;
    n_tests++;
    if (elem_data !== 8'(exp_k(13)) || busy !== 1) begin
      n_fail++;
      $display("FAIL ignored_start_next: data=%0d busy=%b, required %0d 1", elem_data, busy, exp_k(13));
    end
    for (int c = 0; c < 20; c++) begin
      if (done === 1) n_done++;
      tick();
    end
    n_tests++;
    if (n_done != 1 || busy !== 0) begin
      n_fail++;
      $display("FAIL ignored_start_done: pulses=%0d busy=%b, required 1 0", n_done, busy);
    end
  endtask
  task automatic test_reset_mid();
    int n_done = 0;
    r_word = inc_word();
    elem_ready = 1;
    launch();
    tick(11);
    reset = 1;
    tick();
    reset = 0;
    n_tests++;
    if (elem_valid !== 0 || busy !== 0 || ram_address !== 0 || done !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b busy=%b addr=%0d done=%b, required 0 0 0 0",
               elem_valid, busy, ram_address, done);
    end
    for (int c = 0; c < 5; c++) begin
      if (done === 1) n_done++;
      tick();
    end
    n_tests++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: pulses=%0d, required 0", n_done);
    end
    launch();
    n_tests++;
    if (elem_valid !== 1 || elem_data !== 8'(exp_k(0)) || elem_row !== 0 || elem_col !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: valid=%b data=%0d row=%0d col=%0d, required 1 0 0 0",
               elem_valid, elem_data, elem_row, elem_col);
    end
    tick(25);
    n_tests++;
    if (done !== 1) begin
      n_fail++;
      $display("FAIL reset_mid_done: done=%b, required 1", done);
    end
    tick();
  endtask
  task automatic test_back_to_back();
    r_word = inc_word();
    elem_ready = 1;
    launch();
    tick(25);
    n_tests++;
    if (done !== 1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b, required 1", done);
    end
    start = 1;
    tick();
    start = 0;
    n_tests++;
    if (busy !== 1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    tick(2);
    n_tests++;
    if (elem_valid !== 1 || elem_data !== 8'(exp_k(0))) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b data=%0d, required 1 %0d", elem_valid, elem_data, exp_k(0));
    end
    tick();
    n_tests++;
    if (elem_data !== 8'(exp_k(1)) || elem_row !== 3'(exp_k(1) / 5) || elem_col !== 3'(exp_k(1) % 5)) begin
      n_fail++;
      $display("FAIL b2b_second: data=%0d row=%0d col=%0d, required %0d %0d %0d",
               elem_data, elem_row, elem_col, exp_k(1), exp_k(1) / 5, exp_k(1) % 5);
    end
    tick(24);
    n_tests++;
    if (done !== 1) begin
      n_fail++;
      $display("FAIL b2b_done2: done=%b, required 1", done);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_signed();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
